// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker for the two-road light bus.
// Flags bad codes, conflicts, bad sequences and count jumps.
module traffic_monitor #(
  parameter int CNT_MAX = 59,
  parameter int LEN_W   = 8,
  parameter int CYC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light1,
  input  logic [2:0]       light2,
  input  logic [5:0]       count,
  input  logic             clr,
  output logic             illegal,
  output logic             conflict,
  output logic             seq_err,
  output logic             cnt_err,
  output logic             err_pulse,
  output logic [LEN_W-1:0] g1_len,
  output logic [LEN_W-1:0] g2_len,
  output logic [1:0]       len_vld,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {
    ST_X,
    ST_G,
    ST_R,
    ST_Y
  } lamp_t;

  localparam logic [5:0] CMAX = 6'(CNT_MAX);

  function automatic lamp_t decode(input logic [2:0] code);
    lamp_t s;
    case (code)
      3'b100:  s = ST_G;
      3'b010:  s = ST_R;
      3'b001:  s = ST_Y;
      default: s = ST_X;
    endcase
    return s;
  endfunction

  // A change is legal only along G->Y, Y->R or R->G.
  function automatic logic bad_step(
    input lamp_t p,
    input lamp_t c
  );
    logic ok;
    ok = (p == c)
      || (p == ST_G && c == ST_Y)
      || (p == ST_Y && c == ST_R)
      || (p == ST_R && c == ST_G);
    return (p != ST_X) && (c != ST_X) && !ok;
  endfunction

  lamp_t            cur1, cur2;
  lamp_t            prev1, prev2;
  logic [5:0]       prev_cnt;
  logic             armed;
  logic [LEN_W-1:0] run1, run2;

  logic       chk_ill, chk_con, chk_seq, chk_cnt;
  logic [5:0] exp_cnt;
  logic       end_g1, end_g2, r2g;

  // Per-cycle checks from current inputs and registered history.
  always_comb begin
    cur1    = decode(light1);
    cur2    = decode(light2);
    exp_cnt = (prev_cnt == CMAX) ? 6'd0 : prev_cnt + 6'd1;
    chk_ill = (cur1 == ST_X) || (cur2 == ST_X);
    chk_con = !chk_ill
           && (cur1 != ST_R) && (cur2 != ST_R);
    chk_seq = armed
           && (bad_step(prev1, cur1)
            || bad_step(prev2, cur2));
    chk_cnt = (count > CMAX)
           || (armed && count != exp_cnt);
    end_g1  = armed && prev1 == ST_G && cur1 != ST_G;
    end_g2  = armed && prev2 == ST_G && cur2 != ST_G;
    r2g     = armed && prev1 == ST_R && cur1 == ST_G;
  end

  // History, run counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev1     <= ST_X;
      prev2     <= ST_X;
      prev_cnt  <= '0;
      armed     <= 1'b0;
      run1      <= '0;
      run2      <= '0;
      illegal   <= 1'b0;
      conflict  <= 1'b0;
      seq_err   <= 1'b0;
      cnt_err   <= 1'b0;
      err_pulse <= 1'b0;
      g1_len    <= '0;
      g2_len    <= '0;
      len_vld   <= '0;
      cycles    <= '0;
    end else begin
      prev1    <= cur1;
      prev2    <= cur2;
      prev_cnt <= count;
      armed    <= 1'b1;

      if (!armed || cur1 != prev1)
        run1 <= LEN_W'(1);
      else if (run1 != '1)
        run1 <= run1 + LEN_W'(1);

      if (!armed || cur2 != prev2)
        run2 <= LEN_W'(1);
      else if (run2 != '1)
        run2 <= run2 + LEN_W'(1);

      illegal  <= chk_ill | (illegal  & ~clr);
      conflict <= chk_con | (conflict & ~clr);
      seq_err  <= chk_seq | (seq_err  & ~clr);
      cnt_err  <= chk_cnt | (cnt_err  & ~clr);
      err_pulse <= chk_ill | chk_con
                 | chk_seq | chk_cnt;

      len_vld <= {end_g2, end_g1};
      if (end_g1) g1_len <= run1;
      if (end_g2) g2_len <= run2;

      if (r2g && cycles != '1)
        cycles <= cycles + CYC_W'(1);
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: directed vectors for traffic_monitor.
// Expected values are hand-computed per vector.
module tb_traffic_monitor;

  localparam logic [2:0] G  = 3'b100;
  localparam logic [2:0] R  = 3'b010;
  localparam logic [2:0] Y  = 3'b001;
  localparam logic [2:0] BX = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  light1 = R;
  logic [2:0]  light2 = R;
  logic [5:0]  count = '0;
  logic        clr = 1'b0;
  logic        illegal, conflict, seq_err, cnt_err;
  logic        err_pulse;
  logic [7:0]  g1_len, g2_len;
  logic [1:0]  len_vld;
  logic [15:0] cycles;

  int n_chk  = 0;
  int n_fail = 0;
  int cv     = 0;
  int p;
  logic [2:0] a, b;

  traffic_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .light1    (light1),
    .light2    (light2),
    .count     (count),
    .clr       (clr),
    .illegal   (illegal),
    .conflict  (conflict),
    .seq_err   (seq_err),
    .cnt_err   (cnt_err),
    .err_pulse (err_pulse),
    .g1_len    (g1_len),
    .g2_len    (g2_len),
    .len_vld   (len_vld),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [2:0] l1,
    input logic [2:0] l2,
    input logic [5:0] c
  );
    light1 = l1;
    light2 = l2;
    count  = c;
    @(posedge clk);
    #1;
    cv = (c == 6'd59) ? 0 : int'(c) + 1;
  endtask

  task automatic tick(
    input logic [2:0] l1,
    input logic [2:0] l2
  );
    drive(l1, l2, 6'(cv));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    drive(R, R, 6'd0);
    rst = 1'b0;
    cv  = 0;
  endtask

  task automatic check_flags(
    input string      tag,
    input logic [3:0] exp
  );
    check(tag, {28'd0, illegal, conflict,
                seq_err, cnt_err}, {28'd0, exp});
  endtask

  initial begin
    // reset state
    do_reset();
    check_flags("rst_flags", 4'b0000);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_len", {g1_len, g2_len}, 32'd0);
    check("rst_vld", 32'(len_vld), 32'd0);
    check("rst_cyc", 32'(cycles), 32'd0);

    // nominal: R1 30 (G2 25, Y2 5), G1 25, Y1 5
    for (int i = 0; i < 180; i++) begin
      p = i % 60;
      if (p < 30) begin
        a = R;
        b = (p < 25) ? G : Y;
      end else begin
        a = (p < 55) ? G : Y;
        b = R;
      end
      drive(a, b, 6'(p));
      check("nom_vld", 32'(len_vld),
            {30'd0, p == 25, p == 55});
      check("nom_pulse", 32'(err_pulse), 32'd0);
      if (p == 55)
        check("nom_g1", 32'(g1_len), 32'd25);
      if (p == 25)
        check("nom_g2", 32'(g2_len), 32'd25);
    end
    check_flags("nom_flags", 4'b0000);
    check("nom_cyc", 32'(cycles), 32'd3);

    // conflict, hold, clear
    do_reset();
    tick(R, Y);
    tick(G, Y);
    check_flags("con_set", 4'b0100);
    check("con_pulse", 32'(err_pulse), 32'd1);
    tick(Y, R);
    tick(Y, R);
    check_flags("con_hold", 4'b0100);
    check("con_nopulse", 32'(err_pulse), 32'd0);
    clr = 1'b1;
    tick(Y, R);
    clr = 1'b0;
    check_flags("con_clr", 4'b0000);

    // direct G->R on road 1
    do_reset();
    tick(G, R);
    tick(R, R);
    check_flags("seq_set", 4'b0010);
    check("seq_pulse", 32'(err_pulse), 32'd1);

    // illegal code on road 2, no seq error around it
    do_reset();
    tick(R, G);
    tick(R, BX);
    check_flags("ill_set", 4'b1000);
    check("ill_pulse", 32'(err_pulse), 32'd1);
    tick(R, Y);
    check_flags("ill_leave", 4'b1000);
    check("ill_nopulse", 32'(err_pulse), 32'd0);

    // count jump, wrap, repeat
    do_reset();
    drive(R, G, 6'd57);
    drive(R, G, 6'd59);
    check_flags("cnt_jump", 4'b0001);
    check("cnt_pulse1", 32'(err_pulse), 32'd1);
    drive(R, G, 6'd0);
    check("cnt_wrap", 32'(err_pulse), 32'd0);
    drive(R, G, 6'd0);
    check("cnt_pulse2", 32'(err_pulse), 32'd1);
    // clr and error together: set wins
    clr = 1'b1;
    drive(R, G, 6'd7);
    clr = 1'b0;
    check_flags("clr_vs_set", 4'b0001);
    // clr alone clears
    clr = 1'b1;
    drive(R, G, 6'd8);
    clr = 1'b0;
    check_flags("clr_only", 4'b0000);

    // out of range on the unarmed cycle
    do_reset();
    drive(R, G, 6'd60);
    check_flags("cnt_range", 4'b0001);
    // arbitrary in-range start is fine
    do_reset();
    drive(R, G, 6'd33);
    check_flags("cnt_start", 4'b0000);

    // completed short green, then reset mid-green
    do_reset();
    tick(G, R);
    tick(G, R);
    tick(G, R);
    tick(Y, R);
    check("g1_short_vld", 32'(len_vld), 32'd1);
    check("g1_short", 32'(g1_len), 32'd3);
    tick(R, R);
    tick(G, R);
    tick(G, R);
    check("cyc_one", 32'(cycles), 32'd1);
    rst = 1'b1;
    tick(G, R);
    check_flags("mid_rst_flags", 4'b0000);
    check("mid_rst_len", 32'(g1_len), 32'd0);
    check("mid_rst_cyc", 32'(cycles), 32'd0);
    rst = 1'b0;
    drive(R, R, 6'd40);
    check_flags("post_rst", 4'b0000);
    check("post_rst_pulse", 32'(err_pulse), 32'd0);
    check("post_rst_vld", 32'(len_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Passive checker on the two-road traffic-light bus (light1, light2, count) driven by the existing counter/controller pair. It samples the light encodings and the 0–59 phase counter every clock and flags the following:
- illegal light codes;
- conflicting right-of-way;
- illegal phase sequences;
- counter discontinuities.

It also measures green-phase lengths per road and counts completed signal cycles. It sits beside the controller in the top level, or in the bench, and never drives the light bus.

## Interface
- `CNT_MAX`, default 59: terminal value of the phase counter; legal count range is 0..CNT_MAX.
- `LEN_W`, default 8: width of the green-length outputs; saturating.
- `CYC_W`, default 16: width of the completed-cycle counter; saturating.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `light1`  in  3  road-1 lamps, [green, red, yellow] = bits [2,1,0].
- `light2`  in  3  road-2 lamps, same encoding.
- `count`  in  6  phase counter from the counter block.
- `clr`  in  1  synchronous clear of sticky error flags.
- `illegal`  out  1  sticky: either light not exactly one-hot.
- `conflict`  out  1  sticky: both roads non-red in the same cycle.
- `seq_err`  out  1  sticky: illegal lamp transition on either road.
- `cnt_err`  out  1  sticky: count out of range or not previous+1 modulo CNT_MAX+1.
- `err_pulse`  out  1  one-cycle pulse on any newly detected error, whether or not the flag was already set.
- `g1_len`  out  LEN_W  length in cycles of road-1's last completed green.
- `g2_len`  out  LEN_W  same for road 2.
- `len_vld`  out  2  one-cycle pulse; bit0 = g1_len updated, bit1 = g2_len updated.
- `cycles`  out  CYC_W  completed road-1 cycles (R→G transitions on road 1).

## Operation
**Decode.** Per road, the code maps to a lamp state:
- 3'b100 = G
- 3'b010 = R
- 3'b001 = Y
- anything else = X (illegal)

**Registered history.** The block keeps:
- `prev1`, `prev2`: previous decoded states;
- `prev_cnt`: previous count;
- `armed`: set after the first post-reset sample.

**Checks**, evaluated on each edge from the current inputs:
- illegal: either road decodes to X. Checked every cycle, including the unarmed first cycle.
- conflict: neither road is X and both roads are non-R.
- seq_err: only when armed and both the previous and current states of a road are non-X, and the state changed along a transition other than G→Y, Y→R or R→G. No change is legal. An X on either side of a transition is reported only via illegal.
- cnt_err:
  - count > CNT_MAX, on any cycle;
  - when armed, count ≠ (prev_cnt == CNT_MAX ? 0 : prev_cnt+1).

**Flags.** Each sticky flag sets when its check fires and holds until `clr` or `rst`.
- clr and a check firing in the same cycle: the flag ends set (set wins).
- err_pulse = OR of all four checks, registered.

**Green length.**
- Per road, a run counter holds the number of consecutive sampled cycles in the current state. It loads 1 on a state change and saturates at 2^LEN_W−1.
- When a road leaves G (prev = G, current ≠ G, armed), gN_len ← run counter and len_vld[N-1] pulses.
- A green still in progress at reset is discarded.

**Cycle count.** Increments on each armed road-1 R→G transition and saturates at all-ones.

## Timing
- Reset values: all flags 0; err_pulse 0; g1_len = g2_len = 0; len_vld = 0; cycles = 0; armed = 0; history cleared.
- Latency: every output reflects the inputs sampled at edge k immediately after edge k, i.e. one clock.
- The first cycle after reset deasserts is unarmed. Only the illegal, conflict and range checks apply on that cycle.
- Reset asserted mid-operation clears everything at the next edge and disarms. No error or length is reported across the reset boundary.
- Counter wrap CNT_MAX → 0 is legal. Any other jump, including a repeated value, is cnt_err.
- Lengths count sampled clocks. A green held for N edges reports N.

## Test plan
- Nominal controller sequence, road1 G/Y/R with road2 complementary, count 0..59 wrapping, three full cycles → all flags stay 0; cycles = 3; g1_len equals the programmed green length on each len_vld[0] pulse.
- light1 = 3'b100 and light2 = 3'b001 in the same cycle → conflict = 1 and err_pulse = 1 one clock later; conflict holds after the lights recover; clr clears it the following clock.
- Road1 G → R directly (100 → 010) → seq_err = 1 and err_pulse = 1; illegal and conflict stay 0.
- light2 = 3'b110 for one cycle → illegal = 1; no seq_err on entering or leaving X.
- count 57 → 59, then 0 → 0 → cnt_err on both events, err_pulse twice; count = 60 → cnt_err even on the first cycle after reset.
- Error and clr asserted in the same cycle → flag remains 1. rst asserted mid-green then released → outputs 0, and the next unarmed sample raises no seq_err or cnt_err.
